// File: rtl/osd_pkg.sv
// Shared constants, types and the 16x16 seven-segment digit font used by the
// multi-digit on-screen-display overlay.
package osd_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam int LAT = 4;

  typedef logic [3:0] bcd_t;

  // Video timing triple carried alongside the pixel pipeline.
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_e;

  // Bar masks in glyph bit order (bit 15 is column 0).
  localparam logic [GLYPH_W-1:0] ROW_H = 16'h0FF0;
  localparam logic [GLYPH_W-1:0] ROW_L = 16'h3000;
  localparam logic [GLYPH_W-1:0] ROW_R = 16'h000C;

  function automatic logic [6:0] seg_map(input bcd_t code);
    case (code)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One 16-bit glyph row: horizontal bars on rows 1-2/7-8/13-14,
  // vertical bars on rows 3-6 and 9-12.
  function automatic logic [GLYPH_W-1:0] glyph_row(input bcd_t code, input logic [3:0] row);
    logic [6:0]         seg;
    logic [GLYPH_W-1:0] bits;
    seg  = seg_map(code);
    bits = '0;
    if (row inside {4'd1, 4'd2})
      bits = seg[SEG_A] ? ROW_H : '0;
    else if (row inside {[4'd3:4'd6]})
      bits = (seg[SEG_F] ? ROW_L : '0) | (seg[SEG_B] ? ROW_R : '0);
    else if (row inside {4'd7, 4'd8})
      bits = seg[SEG_G] ? ROW_H : '0;
    else if (row inside {[4'd9:4'd12]})
      bits = (seg[SEG_E] ? ROW_L : '0) | (seg[SEG_C] ? ROW_R : '0);
    else if (row inside {4'd13, 4'd14})
      bits = seg[SEG_D] ? ROW_H : '0;
    return bits;
  endfunction

endpackage

// File: rtl/osd_glyph_rom.sv
// Synchronous glyph ROM: address = code*16 + row, one registered 16-bit row out.
module osd_glyph_rom
  import osd_pkg::*;
(
  input  logic               clk,
  input  logic               i_en,
  input  logic [7:0]         i_addr,
  output logic [GLYPH_W-1:0] o_data
);

  logic [GLYPH_W-1:0] r_data;

  // NOTE: ROM read data is not reset; the pipeline's valid bit masks it until real data arrives.
  always_ff @(posedge clk) begin
    if (i_en) r_data <= glyph_row(bcd_t'(i_addr[7:4]), i_addr[3:0]);
  end

  assign o_data = r_data;

endmodule

// File: rtl/multi_digit_osd.sv
// Frame-coherent N-digit decimal overlay mask on a vsync/hsync/de pixel stream,
// with power-of-two magnification, leading-zero blanking and inverse video.
module multi_digit_osd
  import osd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int W_PW       = 11,
  parameter int W_PH       = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [W_PW:0]           x,
  input  logic [W_PH:0]           y,
  input  logic [1:0]              scale,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    invert,
  input  logic                    vsync,
  input  logic                    hsync,
  input  logic                    de,
  output logic                    vsync_o,
  output logic                    hsync_o,
  output logic                    de_o,
  output logic                    q
);

  logic          r_vsync_q;
  logic          r_de_q;
  logic [W_PW:0] r_px;
  logic [W_PH:0] r_ln;
  logic          w_vs_fall;
  logic          w_de_fall;

  bcd_t          r_sh_dig [NUM_DIGITS];
  logic [W_PW:0] r_sh_x;
  logic [W_PH:0] r_sh_y;
  logic [1:0]    r_sh_scale;
  logic          r_sh_en;
  logic          r_sh_lz;
  logic          r_sh_inv;

  assign w_vs_fall = !vsync && r_vsync_q;
  assign w_de_fall = !de && r_de_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
      r_de_q    <= 1'b0;
      r_px      <= '0;
      r_ln      <= '0;
    end else begin
      r_vsync_q <= vsync;
      r_de_q    <= de;
      r_px      <= de ? r_px + 1'b1 : '0;
      // Frame start takes priority over the end-of-line increment.
      if (w_vs_fall)      r_ln <= '0;
      else if (w_de_fall) r_ln <= r_ln + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_sh_dig[i] <= '0;
      r_sh_x     <= '0;
      r_sh_y     <= '0;
      r_sh_scale <= '0;
      r_sh_en    <= 1'b0;
      r_sh_lz    <= 1'b0;
      r_sh_inv   <= 1'b0;
    end else if (w_vs_fall) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_sh_dig[i] <= digits[4*(NUM_DIGITS-1-i) +: 4];
      r_sh_x     <= x;
      r_sh_y     <= y;
      r_sh_scale <= scale;
      r_sh_en    <= enable;
      r_sh_lz    <= blank_lz;
      r_sh_inv   <= invert;
    end
  end

  // Effective per-digit codes: leading zeros become blank, last digit always shown.
  bcd_t w_eff [NUM_DIGITS];
  logic w_zero_run;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_zero_run = r_sh_lz;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_eff[i] = r_sh_dig[i];
      if (r_sh_dig[i] != 4'd0)                      w_zero_run = 1'b0;
      else if (w_zero_run && (i != NUM_DIGITS - 1)) w_eff[i]   = BLANK_CODE;
    end
  end

  // Stage 1: region compare at one extra bit so the far bound cannot wrap.
  logic [2:0]      w_cell_sh;
  logic [W_PW+1:0] w_x_end;
  logic [W_PH+1:0] w_y_end;
  logic            w_in_reg;

  assign w_cell_sh = 3'd4 + {1'b0, r_sh_scale};
  assign w_x_end   = {1'b0, r_sh_x} + ((W_PW+2)'(NUM_DIGITS) << w_cell_sh);
  assign w_y_end   = {1'b0, r_sh_y} + ((W_PH+2)'(GLYPH_H) << r_sh_scale);
  assign w_in_reg  = (r_px >= r_sh_x) && ({1'b0, r_px} < w_x_end) &&
                     (r_ln >= r_sh_y) && ({1'b0, r_ln} < w_y_end);

  logic          r1_act;
  logic [W_PW:0] r1_rx;
  logic [W_PH:0] r1_ry;

  // Stage 2: digit select and ROM address.
  logic [W_PW:0] w_idx;
  logic [W_PW:0] w_rx_s;
  logic [W_PH:0] w_ry_s;
  bcd_t          w_code;

  assign w_idx  = r1_rx >> w_cell_sh;
  assign w_rx_s = r1_rx >> r_sh_scale;
  assign w_ry_s = r1_ry >> r_sh_scale;

  always_comb begin
    w_code = BLANK_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx == (W_PW+1)'(i)) w_code = w_eff[i];
    end
  end

  logic               r2_act;
  logic [7:0]         r2_addr;
  logic [3:0]         r2_col;
  logic               r3_act;
  logic [3:0]         r3_col;
  logic [GLYPH_W-1:0] w_rom_data;
  logic               r_q;
  sync_t              r_sync [LAT];

  osd_glyph_rom u_rom (
    .clk    (clk),
    .i_en   (r2_act),
    .i_addr (r2_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_act  <= 1'b0;
      r1_rx   <= '0;
      r1_ry   <= '0;
      r2_act  <= 1'b0;
      r2_addr <= '0;
      r2_col  <= '0;
      r3_act  <= 1'b0;
      r3_col  <= '0;
      r_q     <= 1'b0;
      for (int i = 0; i < LAT; i++) r_sync[i] <= '0;
    end else begin
      r1_act  <= de && r_sh_en && w_in_reg;
      r1_rx   <= r_px - r_sh_x;
      r1_ry   <= r_ln - r_sh_y;
      r2_act  <= r1_act;
      r2_addr <= {w_code, w_ry_s[3:0]};
      r2_col  <= w_rx_s[3:0];
      r3_act  <= r2_act;
      r3_col  <= r2_col;
      r_q     <= r3_act && (w_rom_data[4'(GLYPH_W-1) - r3_col] ^ r_sh_inv);
      r_sync[0] <= '{vs: vsync, hs: hsync, de: de};
      for (int i = 1; i < LAT; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign vsync_o = r_sync[LAT-1].vs;
  assign hsync_o = r_sync[LAT-1].hs;
  assign de_o    = r_sync[LAT-1].de;
  assign q       = r_q;

endmodule

// File: tb/tb_multi_digit_osd.sv
// Self-checking bench for multi_digit_osd: per-pixel scoreboard against a
// geometric font model, plus per-frame lit-pixel counts derived by hand.
module tb_multi_digit_osd;
  import osd_pkg::*;

  localparam int ND = 4;
  localparam int HB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [11:0] x, y;
  logic [1:0]  scale;
  logic        enable, blank_lz, invert, vsync, hsync, de;
  logic        vsync_o, hsync_o, de_o, q;

  always #5 clk = ~clk;

  multi_digit_osd #(.NUM_DIGITS(ND), .W_PW(11), .W_PH(11)) dut (
    .clk(clk), .rst(rst), .digits(digits), .x(x), .y(y), .scale(scale),
    .enable(enable), .blank_lz(blank_lz), .invert(invert),
    .vsync(vsync), .hsync(hsync), .de(de),
    .vsync_o(vsync_o), .hsync_o(hsync_o), .de_o(de_o), .q(q)
  );

  typedef struct packed { logic vs; logic hs; logic de; logic q; } obs_t;

  typedef struct {
    logic [15:0] dig;
    int x, y, scale;
    bit en, lz, inv;
  } sh_t;

  typedef struct {
    logic [15:0] digits;
    int x, y, scale;
    bit en, lz, inv;
    int fw, fh;
    int mid_line;
    logic [15:0] mid_digits;
    int mid_x;
    bit coincide;
    int rst_line;
    int exp_lit;
  } vec_t;

  obs_t  sb[$];
  sh_t   m_sh;
  bit    m_vs_prev;
  int    total = 0;
  int    bad   = 0;
  int    lit   = 0;
  vec_t  tbl[12];
  string seg_names[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", what, $time, act, exp);
    end
  endtask

  function automatic bit has_seg(input int code, input byte ch);
    string s;
    s = seg_names[code];
    for (int i = 0; i < s.len(); i++) if (s[i] == ch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit font_pix(input int code, input int col, input int row);
    if (code > 9) return 1'b0;
    if (has_seg(code, "a") && row >= 1  && row <= 2  && col >= 4  && col <= 11) return 1'b1;
    if (has_seg(code, "g") && row >= 7  && row <= 8  && col >= 4  && col <= 11) return 1'b1;
    if (has_seg(code, "d") && row >= 13 && row <= 14 && col >= 4  && col <= 11) return 1'b1;
    if (has_seg(code, "f") && row >= 3  && row <= 6  && col >= 2  && col <= 3)  return 1'b1;
    if (has_seg(code, "b") && row >= 3  && row <= 6  && col >= 12 && col <= 13) return 1'b1;
    if (has_seg(code, "e") && row >= 9  && row <= 12 && col >= 2  && col <= 3)  return 1'b1;
    if (has_seg(code, "c") && row >= 9  && row <= 12 && col >= 12 && col <= 13) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_q(input int c, input int l);
    int sp, rx, ry, d, code;
    bit blank;
    if (!m_sh.en) return 1'b0;
    sp = 16 << m_sh.scale;
    if (c < m_sh.x || c >= m_sh.x + ND * sp || l < m_sh.y || l >= m_sh.y + sp) return 1'b0;
    rx    = c - m_sh.x;
    ry    = l - m_sh.y;
    d     = rx / sp;
    code  = int'(m_sh.dig[4*(ND-1-d) +: 4]);
    blank = m_sh.lz && (d != ND - 1);
    for (int k = 0; k <= d; k++) if (m_sh.dig[4*(ND-1-k) +: 4] != 4'd0) blank = 1'b0;
    if (blank) code = 15;
    return font_pix(code, (rx % sp) >> m_sh.scale, ry >> m_sh.scale) ^ m_sh.inv;
  endfunction

  // One clock of stimulus: push the expectation, compare the output due now.
  task automatic cyc(input bit vs, input bit hs, input bit d, input bit r, input int c, input int l);
    obs_t e, a;
    vsync = vs; hsync = hs; de = d; rst = r;
    e = '{vs: vs, hs: hs, de: d, q: d && exp_q(c, l)};
    if (!vs && m_vs_prev) begin
      m_sh.dig = digits; m_sh.x = int'(x); m_sh.y = int'(y); m_sh.scale = int'(scale);
      m_sh.en = enable; m_sh.lz = blank_lz; m_sh.inv = invert;
    end
    m_vs_prev = vs;
    sb.push_back(e);
    if (r) begin
      m_sh = '{default: 0};
      m_vs_prev = 1'b0;
      for (int i = (sb.size() > LAT ? sb.size() - LAT : 0); i < sb.size(); i++) sb[i] = '0;
    end
    @(negedge clk);
    if (sb.size() > LAT) begin
      e = sb.pop_front();
      a = '{vs: vsync_o, hs: hsync_o, de: de_o, q: q};
      check("pixel {vs,hs,de,q}", 32'(a), 32'(e));
      if (q) lit++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    bit r;
    digits = v.digits; x = 12'(v.x); y = 12'(v.y); scale = 2'(v.scale);
    enable = v.en; blank_lz = v.lz; invert = v.inv;
    lit = 0;
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    if (v.coincide) for (int c = 0; c < v.fw; c++) cyc(1'b1, 1'b0, 1'b1, 1'b0, c, 99);
    repeat (HB) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int l = 0; l < v.fh; l++) begin
      for (int c = 0; c < v.fw; c++) begin
        if (l == v.mid_line && c == 0) begin
          digits = v.mid_digits;
          x = 12'(v.mid_x);
        end
        r = (l == v.rst_line) && (c == v.fw / 2);
        cyc(1'b0, 1'b0, 1'b1, r, c, l);
        if (r) check("outputs after rst", 32'({vsync_o, hsync_o, de_o, q}), 32'd0);
      end
      repeat (HB) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    if (v.exp_lit >= 0) check($sformatf("frame %0d lit count", idx), 32'(lit), 32'(v.exp_lit));
  endtask

  function automatic vec_t mk(input logic [15:0] dg, input int px, input int py, input int sc,
                              input bit en, input bit lz, input bit inv,
                              input int fw, input int fh, input int exp_lit);
    vec_t v;
    v = '{digits: dg, x: px, y: py, scale: sc, en: en, lz: lz, inv: inv, fw: fw, fh: fh,
          mid_line: -1, mid_digits: 16'h0, mid_x: 0, coincide: 1'b0, rst_line: -1,
          exp_lit: exp_lit};
    return v;
  endfunction

  initial begin
    // Lit counts: per digit 16 px per horizontal bar and 8 px per vertical bar, x4 per scale step.
    tbl[0]  = mk(16'h1234,  8, 4, 0, 1'b0, 1'b0, 1'b0,  80, 24,   0);
    tbl[1]  = mk(16'h1234,  8, 0, 0, 1'b1, 1'b0, 1'b0,  80, 20, 184);
    tbl[1].coincide = 1'b1;
    tbl[2]  = mk(16'h1234,  8, 4, 0, 1'b1, 1'b0, 1'b0,  80, 32, 184);
    tbl[3]  = mk(16'h0070,  4, 2, 1, 1'b1, 1'b1, 1'b0, 136, 36, 384);
    tbl[4]  = mk(16'h0000,  8, 4, 0, 1'b1, 1'b1, 1'b0,  80, 24,  64);
    tbl[5]  = mk(16'h0000,  8, 4, 0, 1'b1, 1'b1, 1'b1,  80, 24, 960);
    tbl[6]  = mk(16'h1234,  8, 4, 0, 1'b1, 1'b0, 1'b0,  80, 24, 184);
    tbl[6].mid_line = 10; tbl[6].mid_digits = 16'h8888; tbl[6].mid_x = 0;
    tbl[7]  = mk(16'h8888,  0, 4, 0, 1'b1, 1'b0, 1'b0,  80, 24, 320);
    tbl[8]  = mk(16'h8888,  0, 10, 0, 1'b1, 1'b0, 1'b0, 80, 30,   0);
    tbl[8].rst_line = 2;
    tbl[9]  = mk(16'h1234,  8, 4, 0, 1'b1, 1'b0, 1'b0,  80, 24, 184);
    tbl[10] = mk(16'h1234, 60, 4, 0, 1'b1, 1'b0, 1'b0,  80, 24,  24);
    tbl[11] = mk(16'h1234,  0, 0, 2, 1'b1, 1'b0, 1'b0,  80, 66, 384);

    m_sh = '{default: 0};
    m_vs_prev = 1'b0;
    rst = 1'b1; digits = '0; x = '0; y = '0; scale = '0;
    enable = 1'b0; blank_lz = 1'b0; invert = 1'b0;
    vsync = 1'b0; hsync = 1'b0; de = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'({vsync_o, hsync_o, de_o, q}), 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

    // Irregular hsync/de with single-cycle gaps: timing passes through exactly LAT late.
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);

    for (int i = 0; i < 12; i++) run_frame(i, tbl[i]);

    repeat (LAT + 2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
